// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO drained by a UART serializer (8N1 frames).
// Define UART_PARITY_EN to add an even-parity bit after the data (8E1).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  wData,
    input  logic                        wEn,
    output logic                        fifoFull,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        busy,
    output logic                        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_full;

    state_t        r_state;
    logic [7:0]    r_shift;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic          r_tx;
    logic          r_busy;

    state_t        w_state_nxt;
    logic [7:0]    w_shift_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic          w_tx_nxt;
    logic          w_busy_nxt;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_head;
    logic          w_last;

`ifdef UART_PARITY_EN
    logic          r_par;
    logic          w_par_nxt;
`endif

    // A push while full is dropped; fullness is the registered value.
    assign w_push = wEn && !r_full;
    assign w_head = r_mem[r_rd];
    assign w_last = (r_baud == BAUD_LAST);

    // Occupancy update; a push and a pop on the same edge cancel out.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Serializer next-state and registered-output values.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_pop       = 1'b0;
`ifdef UART_PARITY_EN
        w_par_nxt   = r_par;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                w_pop      = (r_count != '0);
            end
            S_START: begin
                if (w_last) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_last) begin
                    w_state_nxt = S_STOP;
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    w_baud_nxt = '0;
                    if (r_count != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
        // Popping the head always launches a new start bit.
        if (w_pop) begin
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
            w_baud_nxt  = '0;
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
`ifdef UART_PARITY_EN
            w_par_nxt   = ^w_head;
`endif
        end
    end

    // FIFO storage; data is captured only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= wData;
        end
    end

    // FIFO pointers and occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    // Serializer state register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
`ifdef UART_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifoFull  = r_full;
    assign fifoCount = r_count;

endmodule
